lane_serializer: RTL



---
 rtl/lane_serializer_pkg.sv | 18 +
 rtl/lane_serializer.sv | 110 +++++++++++
 2 files changed

// File: rtl/lane_serializer_pkg.sv
// Shared types and constants for the lane serializer: FSM state encoding,
// beat-kind codes and the header marker bits.
package lane_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    LANES,
    CHECK
  } ser_state_t;

  localparam logic [1:0] BEAT_HDR  = 2'd0;
  localparam logic [1:0] BEAT_LANE = 2'd1;
  localparam logic [1:0] BEAT_CHK  = 2'd2;

  localparam logic [1:0] HDR_MARK = 2'b10;

endpackage

// File: rtl/lane_serializer.sv
// Captures one multi-lane word plus its select and streams it out as a frame:
// header, lanes 0..NUM_LANES-1, XOR checksum, over a valid/ready link.
module lane_serializer
  import lane_serializer_pkg::*;
#(
  parameter int unsigned NUM_LANES = 3,
  parameter int unsigned LANE_W    = 4
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [1:0]                        in_select,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]  in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANE_W-1:0]                 out_beat,
  output logic                              out_last,
  output logic [1:0]                        out_index,
  output logic [7:0]                        frames_sent
);

  localparam int unsigned CW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(NUM_LANES - 1);

  ser_state_t                       state, state_next;
  logic [1:0]                       sel_q;
  logic [NUM_LANES-1:0][LANE_W-1:0] data_q;
  logic [LANE_W-1:0]                chk_q;
  logic [LANE_W-1:0]                hdr;
  logic [CW-1:0]                    cnt_q;
  logic                             accept;
  logic                             capture;

  always_comb begin
    hdr      = '0;
    hdr[3:0] = {HDR_MARK, sel_q};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_index  = BEAT_HDR;
    out_beat   = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = HEADER;
      end
      HEADER: begin
        out_valid = 1'b1;
        out_beat  = hdr;
        if (out_ready) state_next = LANES;
      end
      LANES: begin
        out_valid = 1'b1;
        out_index = BEAT_LANE;
        out_beat  = data_q[cnt_q];
        if (out_ready && cnt_q == LAST_LANE) state_next = CHECK;
      end
      CHECK: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_index = BEAT_CHK;
        out_beat  = chk_q;
        // Accepting the checksum frees the capture registers in the same edge.
        in_ready  = out_ready;
        if (out_ready) state_next = in_valid ? HEADER : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept  = out_valid && out_ready;
  assign capture = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_q       <= '0;
      data_q      <= '0;
      chk_q       <= '0;
      cnt_q       <= '0;
      frames_sent <= '0;
    end else begin
      if (capture) begin
        sel_q  <= in_select;
        data_q <= in_data;
      end
      if (accept) begin
        case (state)
          HEADER: chk_q <= hdr;
          LANES: begin
            chk_q <= chk_q ^ out_beat;
            cnt_q <= (cnt_q == LAST_LANE) ? '0 : cnt_q + CW'(1);
          end
          CHECK:   frames_sent <= frames_sent + 8'd1;
          default: ;
        endcase
      end
    end
  end

endmodule
